// File: rtl/pool1_pkg.sv
// Shared constants and FSM state type for the pool1 2x2 max-pooling stage.
package pool1_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int N_OUT_DEF  = 144;
  localparam int ADDR_W     = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    FINISHED
  } state_t;
endpackage

// File: rtl/pool_max2.sv
// Combinational signed maximum of two operands; ties return the shared value.
module pool_max2 #(
  parameter int W = 16
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] y
);
  assign y = (a >= b) ? a : b;
endmodule

// File: rtl/pool1_maxpool.sv
// 2x2 max-pooling stage: two-stage compare pipeline writing one pooled value per window.
// Optional build macro POOL1_RELU_EN clamps negative maxima to zero in stage 2.
module pool1_maxpool
  import pool1_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int N_OUT  = N_OUT_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] d0,
  input  logic signed [DATA_W-1:0] d1,
  input  logic signed [DATA_W-1:0] d2,
  input  logic signed [DATA_W-1:0] d3,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [DATA_W-1:0]        wr_data,
  output logic                     done
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_OUT - 1);

  state_t state_reg, state_next;

  logic [ADDR_W-1:0]        acc_cnt_reg;
  logic [ADDR_W-1:0]        wr_addr_reg;
  logic                     s1_valid_reg;
  logic signed [DATA_W-1:0] s1_pair_reg [2];
  logic                     wr_en_reg;
  logic [DATA_W-1:0]        wr_data_reg;

  logic signed [DATA_W-1:0] win [4];
  logic signed [DATA_W-1:0] pair_max [2];
  logic signed [DATA_W-1:0] win_max;
  logic signed [DATA_W-1:0] stage2_val;

  logic accept, last_accept, write, last_write;

  assign win[0] = d0;
  assign win[1] = d1;
  assign win[2] = d2;
  assign win[3] = d3;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_pair
      pool_max2 #(.W(DATA_W)) u_max (
        .a(win[2*gi]),
        .b(win[2*gi+1]),
        .y(pair_max[gi])
      );
    end
  endgenerate

  pool_max2 #(.W(DATA_W)) u_max_final (
    .a(s1_pair_reg[0]),
    .b(s1_pair_reg[1]),
    .y(win_max)
  );

`ifdef POOL1_RELU_EN
  assign stage2_val = win_max[DATA_W-1] ? '0 : win_max;
`else
  assign stage2_val = win_max;
`endif

  assign accept      = enable && in_valid && (state_reg == IDLE || state_reg == RUN);
  assign last_accept = accept && (acc_cnt_reg == LAST);
  // A held wr_en commits to memory only on an enabled edge, so a frozen pulse is one write.
  assign write       = enable && wr_en_reg;
  assign last_write  = write && (wr_addr_reg == LAST);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (enable) state_next = last_accept ? DRAIN : RUN;
      RUN:      if (last_accept) state_next = DRAIN;
      DRAIN:    if (last_write) state_next = FINISHED;
      FINISHED: state_next = FINISHED;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      acc_cnt_reg <= '0;
      wr_addr_reg <= '0;
    end else if (enable) begin
      state_reg <= state_next;
      if (accept && !last_accept) acc_cnt_reg <= acc_cnt_reg + 1'b1;
      if (write && !last_write)   wr_addr_reg <= wr_addr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_reg   <= 1'b0;
      s1_pair_reg[0] <= '0;
      s1_pair_reg[1] <= '0;
      wr_en_reg      <= 1'b0;
      wr_data_reg    <= '0;
    end else if (enable) begin
      s1_valid_reg <= accept;
      if (accept) begin
        s1_pair_reg[0] <= pair_max[0];
        s1_pair_reg[1] <= pair_max[1];
      end
      wr_en_reg <= s1_valid_reg;
      if (s1_valid_reg) wr_data_reg <= stage2_val;
    end
  end

  assign wr_en   = wr_en_reg;
  assign wr_addr = wr_addr_reg;
  assign wr_data = wr_data_reg;
  assign done    = (state_reg == FINISHED);
endmodule
